// File: rtl/stage_sequencer.sv
// stage_sequencer: control sequencer for a five-stage multicycle datapath.
// Fetch/Memory wait on ROM/RAM ready and trap to ERROR after WAIT_TIMEOUT
// consecutive not-ready cycles. NOPs retire straight from DECODE. Halt/run
// control and cycle/instruction performance counters are included.
// Register enables and strobes are a Mealy decode of state plus ready inputs.
module stage_sequencer #(
  parameter int CNT_W        = 16,
  parameter int TO_W         = 4,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             NOP_FLAG,
  input  logic             Mem_Access,
  input  logic             Wb_Write,
  input  logic             ROM_Ready,
  input  logic             Mem_Ready,
  input  logic             Halt_Req,
  input  logic             Run,
  output logic [2:0]       Stage,
  output logic             IR_Enable,
  output logic             PC_Enable,
  output logic             RA_Enable,
  output logic             RB_Enable,
  output logic             RZ_Enable,
  output logic             RM_Enable,
  output logic             RY_Enable,
  output logic             RF_WRITE,
  output logic             ROM1_Read,
  output logic             Instr_Done,
  output logic             Halted,
  output logic             Error,
  output logic [CNT_W-1:0] Cycle_Count,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam logic [TO_W-1:0]  WAIT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  WAIT_LIM  = TO_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] next_wait;
  logic [TO_W-1:0] wait_inc;
  logic            wait_hit;
  logic [2:0]      retire_target;

  logic ir_en, pc_en, ra_en, rb_en, rz_en, rm_en, ry_en, rf_wr;
  logic rom_rd, done, halted_st, error_st;

  // The current not-ready cycle would be the WAIT_TIMEOUT-th in a row.
  assign wait_inc      = wait_cnt + WAIT_ONE;
  assign wait_hit      = (wait_inc == WAIT_LIM);
  assign retire_target = Halt_Req ? S_HALT : S_FETCH;

  // Next-state, wait-counter and output decode from state and ready inputs.
  always_comb begin
    next_state = state;
    next_wait  = wait_cnt;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    ra_en      = 1'b0;
    rb_en      = 1'b0;
    rz_en      = 1'b0;
    rm_en      = 1'b0;
    ry_en      = 1'b0;
    rf_wr      = 1'b0;
    rom_rd     = 1'b0;
    done       = 1'b0;
    halted_st  = 1'b0;
    error_st   = 1'b0;
    case (state)
      S_FETCH: begin
        rom_rd = 1'b1;
        if (ROM_Ready) begin
          ir_en      = 1'b1;
          pc_en      = 1'b1;
          next_state = S_DECODE;
        end else if (wait_hit) begin
          next_state = S_ERROR;
        end else begin
          next_wait = wait_inc;
        end
      end
      S_DECODE: begin
        ra_en = 1'b1;
        rb_en = 1'b1;
        if (NOP_FLAG) begin
          done       = 1'b1;
          next_state = retire_target;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        rz_en      = 1'b1;
        next_state = S_MEMORY;
      end
      S_MEMORY: begin
        if (!Mem_Access) begin
          next_state = S_WRITEBACK;
        end else if (Mem_Ready) begin
          rm_en      = 1'b1;
          next_state = S_WRITEBACK;
        end else if (wait_hit) begin
          next_state = S_ERROR;
        end else begin
          next_wait = wait_inc;
        end
      end
      S_WRITEBACK: begin
        ry_en      = 1'b1;
        rf_wr      = Wb_Write;
        done       = 1'b1;
        next_state = retire_target;
      end
      S_HALT: begin
        halted_st = 1'b1;
        if (Run) begin
          next_state = S_FETCH;
        end else begin
          next_state = S_HALT;
        end
      end
      S_ERROR: begin
        error_st   = 1'b1;
        next_state = S_ERROR;
      end
      default: begin
        // Unused encoding: treat as a fault and trap.
        error_st   = 1'b1;
        next_state = S_ERROR;
      end
    endcase
    // Any stage change (including every ready cycle) restarts the wait count.
    if (next_state != state) begin
      next_wait = '0;
    end else begin
      next_wait = next_wait;
    end
  end

  // State, wait counter and performance counters; Reset overrides everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      Cycle_Count <= '0;
      Instr_Count <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (state <= S_WRITEBACK) begin
        Cycle_Count <= Cycle_Count + CNT_ONE;
      end
      if (done) begin
        Instr_Count <= Instr_Count + CNT_ONE;
      end
    end
  end

  assign Stage      = state;
  assign IR_Enable  = ir_en     & ~Reset;
  assign PC_Enable  = pc_en     & ~Reset;
  assign RA_Enable  = ra_en     & ~Reset;
  assign RB_Enable  = rb_en     & ~Reset;
  assign RZ_Enable  = rz_en     & ~Reset;
  assign RM_Enable  = rm_en     & ~Reset;
  assign RY_Enable  = ry_en     & ~Reset;
  assign RF_WRITE   = rf_wr     & ~Reset;
  assign ROM1_Read  = rom_rd    & ~Reset;
  assign Instr_Done = done      & ~Reset;
  assign Halted     = halted_st & ~Reset;
  assign Error      = error_st  & ~Reset;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus pushes the hand-derived
// expected outputs of every cycle; a negedge monitor pops and compares.
module tb_stage_sequencer;

  logic        Clock, Reset, NOP_FLAG, Mem_Access, Wb_Write;
  logic        ROM_Ready, Mem_Ready, Halt_Req, Run;
  logic [2:0]  Stage;
  logic        IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable;
  logic        RM_Enable, RY_Enable, RF_WRITE, ROM1_Read, Instr_Done;
  logic        Halted, Error;
  logic [15:0] Cycle_Count, Instr_Count;

  stage_sequencer #(.CNT_W(16), .TO_W(4), .WAIT_TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .NOP_FLAG(NOP_FLAG), .Mem_Access(Mem_Access),
    .Wb_Write(Wb_Write), .ROM_Ready(ROM_Ready), .Mem_Ready(Mem_Ready),
    .Halt_Req(Halt_Req), .Run(Run), .Stage(Stage), .IR_Enable(IR_Enable),
    .PC_Enable(PC_Enable), .RA_Enable(RA_Enable), .RB_Enable(RB_Enable),
    .RZ_Enable(RZ_Enable), .RM_Enable(RM_Enable), .RY_Enable(RY_Enable),
    .RF_WRITE(RF_WRITE), .ROM1_Read(ROM1_Read), .Instr_Done(Instr_Done),
    .Halted(Halted), .Error(Error), .Cycle_Count(Cycle_Count),
    .Instr_Count(Instr_Count)
  );

  localparam logic [11:0] F_IR  = 12'h800, F_PC  = 12'h400, F_RA   = 12'h200;
  localparam logic [11:0] F_RB  = 12'h100, F_RZ  = 12'h080, F_RM   = 12'h040;
  localparam logic [11:0] F_RY  = 12'h020, F_RF  = 12'h010, F_ROM  = 12'h008;
  localparam logic [11:0] F_DONE= 12'h004, F_HLT = 12'h002, F_ERR  = 12'h001;
  localparam logic [11:0] F_NONE= 12'h000;

  typedef struct {
    logic [14:0] sig;
    logic [15:0] cyc;
    logic [15:0] ins;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cyc = 16'd0;
  logic [15:0] exp_ins = 16'd0;
  string       scen = "init";

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor: every cycle the DUT presents, compare it with the oldest expectation.
  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {Stage, IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable,
             RM_Enable, RY_Enable, RF_WRITE, ROM1_Read, Instr_Done, Halted, Error};
      checks++;
      if (act !== e.sig || Cycle_Count !== e.cyc || Instr_Count !== e.ins) begin
        errors++;
        $display("FAIL %s: got stage=%0d flags=%h cyc=%0d ins=%0d, expected stage=%0d flags=%h cyc=%0d ins=%0d",
                 e.name, act[14:12], act[11:0], Cycle_Count, Instr_Count,
                 e.sig[14:12], e.sig[11:0], e.cyc, e.ins);
      end
    end
  end

  // Watchdog: the bench is time-bounded regardless of DUT behaviour.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // One cycle: push expected outputs for the current inputs, then advance.
  task automatic step(input string nm, input logic [2:0] st, input logic [11:0] fl);
    exp_t e;
    logic rst;
    e.sig  = {st, fl};
    e.cyc  = exp_cyc;
    e.ins  = exp_ins;
    e.name = {scen, "/", nm};
    q.push_back(e);
    rst = Reset;
    @(posedge Clock);
    #1;
    if (rst) begin
      exp_cyc = 16'd0;
      exp_ins = 16'd0;
    end else begin
      if (st <= 3'd4) exp_cyc = exp_cyc + 16'd1;
      if ((fl & F_DONE) != F_NONE) exp_ins = exp_ins + 16'd1;
    end
  endtask

  // Full (non-NOP) instruction with optional ROM/RAM wait states and halt.
  task automatic instr(input int rom_wait, input logic mem_acc, input int mem_wait,
                       input logic wb, input logic halt);
    ROM_Ready = 1'b0;
    Mem_Ready = 1'b1;
    for (int i = 0; i < rom_wait; i++) step("fetch_wait", 3'd0, F_ROM);
    ROM_Ready = 1'b1;
    step("fetch", 3'd0, F_IR | F_PC | F_ROM);
    step("decode", 3'd1, F_RA | F_RB);
    step("execute", 3'd2, F_RZ);
    Mem_Access = mem_acc;
    Mem_Ready  = 1'b0;
    for (int i = 0; i < mem_wait; i++) step("mem_wait", 3'd3, F_NONE);
    Mem_Ready = 1'b1;
    step("memory", 3'd3, mem_acc ? F_RM : F_NONE);
    Mem_Access = 1'b0;
    Wb_Write   = wb;
    Halt_Req   = halt;
    step("writeback", 3'd4, F_RY | F_DONE | (wb ? F_RF : F_NONE));
  endtask

  initial begin
    Reset = 1'b1; NOP_FLAG = 1'b0; Mem_Access = 1'b0; Wb_Write = 1'b1;
    ROM_Ready = 1'b1; Mem_Ready = 1'b1; Halt_Req = 1'b0; Run = 1'b0;
    @(posedge Clock);
    #1;
    scen = "reset";
    step("hold", 3'd0, F_NONE);
    Reset = 1'b0;

    scen = "alu10";
    for (int i = 0; i < 10; i++) instr(0, 1'b0, 0, 1'b1, 1'b0);
    scen = "alu10_counts";
    if (exp_cyc != 16'd50 || exp_ins != 16'd10) begin
      errors++;
      $display("FAIL alu10_model: got cyc=%0d ins=%0d, expected cyc=50 ins=10", exp_cyc, exp_ins);
    end
    checks++;

    scen = "alu_nowb_run_ignored";
    Run = 1'b1;
    instr(0, 1'b0, 0, 1'b0, 1'b0);
    Run = 1'b0;

    scen = "nop";
    NOP_FLAG = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("fetch", 3'd0, F_IR | F_PC | F_ROM);
      step("decode", 3'd1, F_RA | F_RB | F_DONE);
    end
    NOP_FLAG = 1'b0;

    scen = "rom_wait3";
    instr(3, 1'b0, 0, 1'b1, 1'b0);
    scen = "load_wait3";
    instr(0, 1'b1, 3, 1'b1, 1'b0);
    scen = "store";
    instr(0, 1'b1, 0, 1'b0, 1'b0);
    scen = "wait_limit_edge";
    instr(14, 1'b1, 14, 1'b1, 1'b0);

    scen = "halt_wb";
    instr(0, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step("halted", 3'd5, F_HLT);
    Run = 1'b1;
    step("run", 3'd5, F_HLT);
    Run = 1'b0;
    Halt_Req = 1'b0;
    scen = "after_run";
    instr(0, 1'b0, 0, 1'b1, 1'b0);

    scen = "halt_nop";
    NOP_FLAG = 1'b1;
    Halt_Req = 1'b1;
    step("fetch", 3'd0, F_IR | F_PC | F_ROM);
    step("decode", 3'd1, F_RA | F_RB | F_DONE);
    step("halted", 3'd5, F_HLT);
    Run = 1'b1;
    step("run", 3'd5, F_HLT);
    Run = 1'b0;
    Halt_Req = 1'b0;
    NOP_FLAG = 1'b0;

    scen = "reset_midwait";
    step("fetch", 3'd0, F_IR | F_PC | F_ROM);
    step("decode", 3'd1, F_RA | F_RB);
    step("execute", 3'd2, F_RZ);
    Mem_Access = 1'b1;
    Mem_Ready  = 1'b0;
    step("mem_wait", 3'd3, F_NONE);
    step("mem_wait", 3'd3, F_NONE);
    Reset = 1'b1;
    step("reset_cycle", 3'd3, F_NONE);
    Reset = 1'b0;
    Mem_Access = 1'b0;
    scen = "after_reset";
    instr(0, 1'b0, 0, 1'b1, 1'b0);

    scen = "rom_timeout";
    ROM_Ready = 1'b0;
    for (int i = 0; i < 15; i++) step("fetch_wait", 3'd0, F_ROM);
    ROM_Ready = 1'b1;
    step("error_ready_ignored", 3'd7, F_ERR);
    Run = 1'b1;
    step("error_run_ignored", 3'd7, F_ERR);
    Run = 1'b0;
    step("error_sticky", 3'd7, F_ERR);
    Reset = 1'b1;
    step("reset_cycle", 3'd7, F_NONE);
    Reset = 1'b0;
    scen = "after_error";
    instr(0, 1'b0, 0, 1'b1, 1'b0);

    @(negedge Clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised successor to the fixed free-running stage counter and enable tracker. It drives the five-stage multicycle datapath (Fetch, Decode, Execute, Memory, Write Back) with ready-based wait states on ROM and RAM, a NOP short-circuit, halt/run control and a wait-timeout error trap. It sits between the instruction decoder flags and the datapath register enables, and adds cycle and instruction performance counters.

Parameters:
CNT_W, 16, width of Cycle_Count and Instr_Count.
TO_W, 4, width of the wait-state counter.
WAIT_TIMEOUT, 15, consecutive not-ready cycles in one wait stage before trapping to ERROR. Legal range 1..2^TO_W-1.

Ports:
Clock  in  1  system clock; all state changes on the rising edge.
Reset  in  1  synchronous, active-high reset.
NOP_FLAG  in  1  current instruction is a NOP; sampled in DECODE.
Mem_Access  in  1  instruction uses RAM; sampled in MEMORY.
Wb_Write  in  1  instruction writes the register file; sampled in WRITEBACK.
ROM_Ready  in  1  instruction word valid this cycle.
Mem_Ready  in  1  RAM access complete this cycle.
Halt_Req  in  1  stop after the current instruction retires.
Run  in  1  leave HALT.
Stage  out  3  state code: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, ERROR=7.
IR_Enable, PC_Enable  out  1 each  instruction register and PC load.
RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable  out  1 each  datapath register loads.
RF_WRITE  out  1  register file write strobe.
ROM1_Read  out  1  ROM read request.
Instr_Done  out  1  one-cycle retire pulse.
Halted  out  1  high in HALT.
Error  out  1  high in ERROR.
Cycle_Count  out  CNT_W  cycles spent in stages 0-4.
Instr_Count  out  CNT_W  retired instructions.

Behaviour:
- Reset dominates every other input in any state, including mid-wait. Next state is FETCH. Wait counter, Cycle_Count and Instr_Count clear to 0.
- All enables, strobes and status outputs are 0 during the Reset cycle. Status outputs are Instr_Done, Halted and Error.
- Outputs are a combinational decode of the state register and the current ready inputs (Mealy). A stage lasts at least one cycle.
- FETCH:
  - ROM1_Read is high for every cycle in the state.
  - On the cycle ROM_Ready=1: IR_Enable=PC_Enable=1 and the next state is DECODE.
  - Otherwise the state holds and the wait counter increments.
- DECODE:
  - RA_Enable=RB_Enable=1 for one cycle.
  - If NOP_FLAG=1: Instr_Done=1 and the next state is the retire target (below), skipping EXECUTE, MEMORY and WRITEBACK.
  - Otherwise the next state is EXECUTE.
- EXECUTE: RZ_Enable=1 for one cycle; the next state is MEMORY.
- MEMORY:
  - If Mem_Access=0: one cycle, RM_Enable=0, next state WRITEBACK.
  - If Mem_Access=1: hold until Mem_Ready=1, incrementing the wait counter. On the ready cycle RM_Enable=1 and the next state is WRITEBACK.
- WRITEBACK:
  - RY_Enable=1 and RF_WRITE=Wb_Write.
  - Instr_Done=1; the next state is the retire target.
- Retire target: HALT if Halt_Req=1 on the retire cycle, otherwise FETCH.
- HALT:
  - Halted=1 and all enables are 0.
  - Run=1 moves the state to FETCH the next cycle.
  - Halt_Req is ignored in HALT. Run is ignored outside HALT.
- Wait counter:
  - Clears on entry to FETCH or MEMORY and on any ready cycle.
  - If it reaches WAIT_TIMEOUT with ready still 0, the next state is ERROR.
  - With WAIT_TIMEOUT=15, a 15th consecutive not-ready cycle traps. Ready arriving on the cycle the count would hit the limit takes priority: the stage advances normally.
- ERROR: Error=1, all enables are 0, and the state is sticky until Reset.
- Cycle_Count increments on every non-reset cycle in stages 0-4 and wraps at 2^CNT_W. It is frozen in HALT and ERROR.
- Instr_Count increments on each Instr_Done and wraps.
- Simultaneous events: a ROM_Ready or Mem_Ready pulse outside its own wait stage has no effect.

Test Plan:
- ALU instruction, Mem_Access=0, Wb_Write=1, ROM_Ready and Mem_Ready tied high, 10 instructions -> Stage cycles 0,1,2,3,4 (5 cycles per instruction); Instr_Count=10, Cycle_Count=50; RF_WRITE pulses once per instruction, in WRITEBACK.
- NOP_FLAG=1 in DECODE -> Stage 0,1,0; Instr_Done pulses in DECODE; no RZ, RM, RY or RF_WRITE pulse; 2 cycles per instruction.
- Load with Mem_Access=1 and Mem_Ready low for 3 cycles -> MEMORY lasts 4 cycles; RM_Enable high only on the 4th; instruction takes 8 cycles.
- ROM_Ready held low, WAIT_TIMEOUT=15 -> Error=1 and Stage=7 after 15 FETCH cycles; a 16th-cycle ROM_Ready is ignored; Reset returns Stage=0 with counters 0.
- Halt_Req=1 during WRITEBACK -> Stage=5, Halted=1, Cycle_Count frozen for 20 idle cycles; Run pulse -> Stage=0 the next cycle.
- Reset asserted in MEMORY mid-wait -> next cycle Stage=0, all enables 0, Instr_Count=0; the interrupted instruction is not retired.
